// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: connects CPU loads and stores (byte, halfword or word) to a
// word-organised RAM. The RAM has one whole-word write enable and a
// combinational read port.
//   Sub-word stores are done as read-modify-write. Loads extract the addressed
//   lane and sign- or zero-extend it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req                 access request, sampled only in IDLE
//   is_store            1 = store, 0 = load
//   size                00 byte, 01 halfword, 10 word, 11 invalid
//   unsigned_ld         1 = zero-extend sub-word loads
//   byte_addr           CPU byte address (ADDR_W+2 bits)
//   wdata               store data (low byte or halfword for sub-word stores)
//   rdata               registered load result
//   done                one-cycle completion pulse
//   err                 misaligned or invalid-size access, valid with done
//   busy                high while not IDLE
//   ram_addr/ram_din    RAM word address and write data
//   ram_we              RAM write enable
//   ram_dout            RAM combinational read data
module ram_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W+1:0] byte_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic              uns_q;
  logic [15:0]       wdata_q;   // only the low half is needed after IDLE
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              err_q;

  // Request decode. It is only meaningful in IDLE.
  logic accept, misalign, invalid, bad;

  always_comb begin
    accept   = (state_q == S_IDLE) && req;
    invalid  = (size == 2'b11);
    misalign = ((size == 2'b01) && byte_addr[0]) ||
               ((size == 2'b10) && (byte_addr[1:0] != 2'b00));
    bad      = invalid || misalign;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad)                           state_d = S_DONE;
          else if (is_store && size == 2'b10) state_d = S_WR;
          else                               state_d = S_RD;
        end
      end
      S_RD:    state_d = store_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs. Gating the write enable with rst makes a reset that
  // coincides with the WR cycle drop the write.
  always_comb begin
    busy   = (state_q != S_IDLE);
    ram_we = (state_q == S_WR) && !rst;
  end

  // Lane extraction for loads. This is the value captured at the end of RD.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: ld_byte = ram_dout[7:0];
      2'd1: ld_byte = ram_dout[15:8];
      2'd2: ld_byte = ram_dout[23:16];
      2'd3: ld_byte = ram_dout[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = ram_dout;
    endcase
  end

  // Read-modify-write merge for sub-word stores.
  logic [31:0] st_merge;

  always_comb begin
    st_merge = ram_dout;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: st_merge[7:0]   = wdata_q[7:0];
        2'd1: st_merge[15:8]  = wdata_q[7:0];
        2'd2: st_merge[23:16] = wdata_q[7:0];
        2'd3: st_merge[31:24] = wdata_q[7:0];
        default: st_merge = ram_dout;
      endcase
    end else if (addr_q[1]) begin
      st_merge[31:16] = wdata_q;
    end else begin
      st_merge[15:0]  = wdata_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 16'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // done/err are high exactly while the FSM sits in DONE.
      done_q <= (state_d == S_DONE);
      err_q  <= accept && bad;
      if (accept) begin
        addr_q  <= byte_addr;
        size_q  <= size;
        store_q <= is_store;
        uns_q   <= unsigned_ld;
        wdata_q <= wdata[15:0];
        if (bad) rdata_q <= 32'h0;
        else if (is_store && size == 2'b10) merge_q <= wdata;
      end
      if (state_q == S_RD) begin
        if (store_q) merge_q <= st_merge;
        else         rdata_q <= ld_ext;
      end
    end
  end

  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ram_din  = merge_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;
  localparam int ADDR_W = 14;
  localparam int TOP    = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              is_store;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W+1:0] byte_addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .size(size),
    .unsigned_ld(unsigned_ld), .byte_addr(byte_addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // RAM model. The bench preload port writes through the same process as the DUT.
  logic [31:0]       mem [0:TOP];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = 32'h0;

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwe;
    int          wecyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = idx[ADDR_W-1:0]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one access. The expected result is pushed at drive time and popped
  // when done appears. Latency k counts edges after the sampling edge (cycle 0).
  task automatic access(input string tag, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [15:0] a, input logic [31:0] wd,
                        input logic [31:0] ex_rd, input logic ex_err,
                        input int ex_lat, input int ex_nwe, input int ex_wecyc);
    exp_t e;
    int   nwe;
    int   wecyc;
    bit   got;
    e = '{ex_rd, ex_err, ex_lat, ex_nwe, ex_wecyc};
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b1; is_store = st; size = sz; unsigned_ld = uns;
    byte_addr = a; wdata = wd;
    nwe = 0; wecyc = -1; got = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_we) begin nwe++; wecyc = k; end
      if (done) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check({tag, " latency"}, k, e.lat);
        check({tag, " rdata"}, rdata, e.rd);
        check({tag, " err"}, {31'h0, err}, {31'h0, e.er});
        check({tag, " we_count"}, nwe, e.nwe);
        check({tag, " we_cycle"}, wecyc, e.wecyc);
        @(negedge clk);
        check({tag, " done_pulse"}, {30'h0, done, busy}, 32'h0);
        break;
      end
    end
    if (!got) begin
      e = sb_q.pop_front();
      check({tag, " timeout"}, 32'h0, 32'h1);
    end
  endtask

  int ndone;
  bit saw_wr;

  initial begin
    rst = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    byte_addr = '0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset ctrl", {28'h0, done, err, busy, ram_we}, 32'h0);
    check("reset ram_addr", {18'h0, ram_addr}, 32'h0);
    check("reset ram_din", ram_din, 32'h0);
    rst = 1'b0;

    poke(4, 32'h88442211);
    poke(TOP, 32'h0BADF00D);

    // Loads: lane extraction and extension
    access("lb 13",  1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, -1);
    access("lbu 13", 1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'h00000088, 1'b0, 2, 0, -1);
    access("lb 10",  1'b0, 2'b00, 1'b0, 16'h0010, 32'h0, 32'h00000011, 1'b0, 2, 0, -1);
    access("lh 12",  1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, 32'hFFFF8844, 1'b0, 2, 0, -1);
    access("lhu 10", 1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'h00002211, 1'b0, 2, 0, -1);
    access("lw 10",  1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h88442211, 1'b0, 2, 0, -1);

    // Stores: rdata holds the last load value
    access("sb 11", 1'b1, 2'b00, 1'b0, 16'h0011, 32'h000000AB, 32'h88442211, 1'b0, 3, 1, 2);
    check("sb 11 mem4", mem[4], 32'h8844AB11);
    poke(4, 32'h88442211);
    access("sh 12", 1'b1, 2'b01, 1'b0, 16'h0012, 32'h1234CAFE, 32'h88442211, 1'b0, 3, 1, 2);
    check("sh 12 mem4", mem[4], 32'hCAFE2211);
    access("sw 14", 1'b1, 2'b10, 1'b0, 16'h0014, 32'hDEADBEEF, 32'h88442211, 1'b0, 2, 1, 1);
    check("sw 14 mem5", mem[5], 32'hDEADBEEF);

    // Errors clear rdata and never touch RAM
    access("lw 12 err", 1'b0, 2'b10, 1'b0, 16'h0012, 32'h0, 32'h0, 1'b1, 1, 0, -1);
    access("lw 10 b",   1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hCAFE2211, 1'b0, 2, 0, -1);
    access("lh 11 err", 1'b0, 2'b01, 1'b0, 16'h0011, 32'h0, 32'h0, 1'b1, 1, 0, -1);
    access("lw 14",     1'b0, 2'b10, 1'b0, 16'h0014, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, -1);
    access("sz11 err",  1'b1, 2'b11, 1'b0, 16'h0010, 32'h55555555, 32'h0, 1'b1, 1, 0, -1);
    check("sz11 mem4", mem[4], 32'hCAFE2211);

    // Highest word address
    access("lw top",  1'b0, 2'b10, 1'b0, 16'hFFFC, 32'h0, 32'h0BADF00D, 1'b0, 2, 0, -1);
    access("lhu top", 1'b0, 2'b01, 1'b1, 16'hFFFE, 32'h0, 32'h00000BAD, 1'b0, 2, 0, -1);
    access("sb top",  1'b1, 2'b00, 1'b0, 16'hFFFF, 32'h0000007E, 32'h00000BAD, 1'b0, 3, 1, 2);
    check("sb top mem", mem[TOP], 32'h7EADF00D);

    // Reset during the WR cycle of a byte store
    poke(4, 32'h88442211);
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; size = 2'b00; unsigned_ld = 1'b0;
    byte_addr = 16'h0010; wdata = 32'h00000055;
    saw_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_we) begin saw_wr = 1'b1; break; end
    end
    check("rst wr reached", {31'h0, saw_wr}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst ctrl", {28'h0, done, err, busy, ram_we}, 32'h0);
    check("rst rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst mem4", mem[4], 32'h88442211);
    check("rst idle", {30'h0, done, busy}, 32'h0);

    // A req raised while busy is dropped: a word store that would overwrite word 5
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
    byte_addr = 16'h0010; wdata = 32'h0;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b1; is_store = 1'b1; byte_addr = 16'h0014; wdata = 32'h01020304;
      end else begin
        req = 1'b0;
      end
      if (done) ndone++;
    end
    check("busy req ndone", ndone, 1);
    check("busy req rdata", rdata, 32'h88442211);
    check("busy req mem5", mem[5], 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
